// File: rtl/alu_requester_pkg.sv
// -----------------------------------------------------------------------------
// alu_requester_pkg
// Shared definitions for the ALU requester: default widths, default timeout
// length and the requester FSM state encoding.
// -----------------------------------------------------------------------------
package alu_requester_pkg;

    localparam int SIZEDATA_DEF      = 8;
    localparam int SIZEOP_DEF        = 6;
    localparam int TIMEOUT_TICKS_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_A   = 3'd1,
        WAIT_A   = 3'd2,
        SEND_B   = 3'd3,
        WAIT_B   = 3'd4,
        SEND_OP  = 3'd5,
        WAIT_OP  = 3'd6,
        WAIT_RES = 3'd7
    } state_t;

endpackage

// File: rtl/alu_requester_tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
// Counts baud ticks while enabled and flags the cycle in which the TICKS-th
// tick arrives.
//   i_clock  : system clock
//   i_reset  : synchronous active-high reset
//   clear    : zero the count (has priority over counting)
//   enable   : count ticks only while high
//   tick     : baud-rate tick
//   expired  : combinational, high in the cycle the final tick is presented
// -----------------------------------------------------------------------------
module tick_timer
    import alu_requester_pkg::*;
#(
    parameter int TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    localparam int CW = $clog2(TICKS + 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clock) begin
        if (i_reset || clear) begin
            count <= '0;
        end else if (enable && tick) begin
            count <= count + 1'b1;
        end
    end

    // Flag on the final tick itself so the FSM can react in the same cycle
    // and let a coincident result take precedence.
    assign expired = enable && tick && (count == CW'(TICKS - 1));

endmodule

// File: rtl/alu_requester.sv
// -----------------------------------------------------------------------------
// alu_requester
// Sends operand A, operand B and the zero-extended opcode over a UART TX
// handshake, then waits for a single result byte from UART RX, giving up
// after TIMEOUT_TICKS baud ticks.
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_tick                    : baud tick, used only for the result timeout
//   i_start, i_datoa/b, i_opcode : request pulse and operands (sampled on start)
//   o_tx_signal, o_tx_data_byte, i_tx_done : UART TX strobe/byte/complete
//   i_rx_done, i_rx_data      : UART RX byte valid/byte
//   o_busy                    : transaction in progress
//   o_result, o_result_valid  : last result byte and its update pulse
//   o_timeout                 : pulse when the result wait expires
// -----------------------------------------------------------------------------
module alu_requester
    import alu_requester_pkg::*;
#(
    parameter int SIZEDATA      = SIZEDATA_DEF,
    parameter int SIZEOP        = SIZEOP_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic                i_start,
    input  logic [SIZEDATA-1:0] i_datoa,
    input  logic [SIZEDATA-1:0] i_datob,
    input  logic [SIZEOP-1:0]   i_opcode,
    output logic                o_tx_signal,
    output logic [SIZEDATA-1:0] o_tx_data_byte,
    input  logic                i_tx_done,
    input  logic                i_rx_done,
    input  logic [SIZEDATA-1:0] i_rx_data,
    output logic                o_busy,
    output logic [SIZEDATA-1:0] o_result,
    output logic                o_result_valid,
    output logic                o_timeout
);

    state_t state, state_next;

    logic [SIZEDATA-1:0] a_q;
    logic [SIZEDATA-1:0] b_q;
    logic [SIZEOP-1:0]   op_q;
    logic                timer_clear;
    logic                timer_en;
    logic                expired;

    function automatic logic [SIZEDATA-1:0] zext_op(input logic [SIZEOP-1:0] op);
        return SIZEDATA'(op);
    endfunction

    tick_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_tick_timer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .tick    (i_tick),
        .expired (expired)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_tx_signal = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        o_busy      = (state != IDLE);
        case (state)
            IDLE:     if (i_start) state_next = SEND_A;
            SEND_A: begin
                o_tx_signal = 1'b1;
                state_next  = WAIT_A;
            end
            WAIT_A:   if (i_tx_done) state_next = SEND_B;
            SEND_B: begin
                o_tx_signal = 1'b1;
                state_next  = WAIT_B;
            end
            WAIT_B:   if (i_tx_done) state_next = SEND_OP;
            SEND_OP: begin
                o_tx_signal = 1'b1;
                state_next  = WAIT_OP;
            end
            WAIT_OP: begin
                // Counter starts from zero on the way into WAIT_RES.
                if (i_tx_done) begin
                    state_next  = WAIT_RES;
                    timer_clear = 1'b1;
                end
            end
            WAIT_RES: begin
                timer_en = 1'b1;
                if (i_rx_done || expired) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // The TX byte register is loaded on the transition into each SEND state,
    // so it is already valid with the strobe and holds until the next load.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            o_tx_data_byte <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_result_valid <= 1'b0;
            o_timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_q            <= i_datoa;
                        b_q            <= i_datob;
                        op_q           <= i_opcode;
                        o_tx_data_byte <= i_datoa;
                    end
                end
                WAIT_A:   if (i_tx_done) o_tx_data_byte <= b_q;
                WAIT_B:   if (i_tx_done) o_tx_data_byte <= zext_op(op_q);
                WAIT_RES: begin
                    // A result arriving with the final tick wins.
                    if (i_rx_done) begin
                        o_result       <= i_rx_data;
                        o_result_valid <= 1'b1;
                    end else if (expired) begin
                        o_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_requester.sv
module tb_alu_requester;

    localparam int SD = 8;
    localparam int SO = 6;
    localparam int TT = 16;

    logic          i_clock = 1'b0;
    logic          i_reset, i_tick, i_start, i_tx_done, i_rx_done;
    logic [SD-1:0] i_datoa, i_datob, i_rx_data;
    logic [SO-1:0] i_opcode;
    logic          o_tx_signal, o_busy, o_result_valid, o_timeout;
    logic [SD-1:0] o_tx_data_byte, o_result;

    int checks = 0;
    int errors = 0;

    logic [SD-1:0] exp_tx_q[$];
    logic [SD:0]   exp_evt_q[$];   // bit SD set = timeout, else result value
    logic [SD-1:0] last_res;
    logic [SD-1:0] line_b[3];
    bit            auto_tick, inj_start, inj_rx;
    logic [SO-1:0] ops[7];

    alu_requester #(
        .SIZEDATA      (SD),
        .SIZEOP        (SO),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tick         (i_tick),
        .i_start        (i_start),
        .i_datoa        (i_datoa),
        .i_datob        (i_datob),
        .i_opcode       (i_opcode),
        .o_tx_signal    (o_tx_signal),
        .o_tx_data_byte (o_tx_data_byte),
        .i_tx_done      (i_tx_done),
        .i_rx_done      (i_rx_done),
        .i_rx_data      (i_rx_data),
        .o_busy         (o_busy),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_timeout      (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    // Reference ALU as seen on the far side of the UART link.
    function automatic logic [SD-1:0] alu(input logic [SD-1:0] a, input logic [SD-1:0] b,
                                          input logic [SO-1:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; pulses default low, operands scrambled to prove latching.
    task automatic step();
        @(posedge i_clock);
        #1;
        i_start   = 1'b0;
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        i_tick    = auto_tick ? ($urandom_range(0, 3) == 0) : 1'b0;
        i_datoa   = SD'($urandom);
        i_datob   = SD'($urandom);
        i_opcode  = SO'($urandom);
        i_rx_data = SD'($urandom);
    endtask

    task automatic monitor();
        bit            prev_tx = 1'b0;
        bit            holding = 1'b0;
        logic [SD-1:0] held = '0;
        logic [SD:0]   e;
        forever begin
            @(negedge i_clock);
            if (holding) check("tx_byte_stable", o_tx_data_byte, held);
            if (o_tx_signal) begin
                check("tx_strobe_gap", prev_tx, 0);
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got strobe byte 0x%0h expected no strobe", o_tx_data_byte);
                end else begin
                    check("tx_byte", o_tx_data_byte, exp_tx_q.pop_front());
                end
                holding = 1'b1;
                held    = o_tx_data_byte;
            end
            if (i_tx_done || i_reset) holding = 1'b0;
            prev_tx = o_tx_signal;
            if (o_result_valid || o_timeout) begin
                if (exp_evt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_unexpected: got valid=%0b timeout=%0b expected none",
                             o_result_valid, o_timeout);
                end else begin
                    e = exp_evt_q.pop_front();
                    check("evt_kind", {o_timeout, o_result_valid}, e[SD] ? 2'b10 : 2'b01);
                    if (!e[SD]) check("result_value", o_result, e[SD-1:0]);
                end
            end
        end
    endtask

    task automatic start_txn(input logic [SD-1:0] a, input logic [SD-1:0] b, input logic [SO-1:0] op);
        step();
        i_start  = 1'b1;
        i_datoa  = a;
        i_datob  = b;
        i_opcode = op;
        exp_tx_q.push_back(a);
        exp_tx_q.push_back(b);
        exp_tx_q.push_back(SD'(op));
    endtask

    // UART TX emulation: acknowledge each strobe after 1-4 cycles.
    task automatic serve_tx(input int ndone);
        int got = 0, nstrobe = 0, cnt = 0, budget = 0;
        bit pending = 1'b0, did_s = 1'b0, did_r = 1'b0;
        while (got < ndone && budget < 200) begin
            step();
            budget++;
            if (o_tx_signal) begin
                if (nstrobe < 3) line_b[nstrobe] = o_tx_data_byte;
                nstrobe++;
                pending = 1'b1;
                cnt     = $urandom_range(1, 4);
            end else if (pending) begin
                if (inj_start && nstrobe == 2 && !did_s) begin
                    i_start = 1'b1;
                    i_datoa = 8'hFF;
                    did_s   = 1'b1;
                end
                if (inj_rx && nstrobe == 1 && !did_r) begin
                    i_rx_done = 1'b1;
                    i_rx_data = 8'h55;
                    did_r     = 1'b1;
                end
                cnt--;
                if (cnt == 0) begin
                    i_tx_done = 1'b1;
                    pending   = 1'b0;
                    got++;
                end
            end
        end
        check("tx_handshakes", got, ndone);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 100) begin
            step();
            n++;
        end
        check("busy_falls", o_busy, 0);
    endtask

    // Far end replies with the ALU of the bytes actually seen on the line.
    task automatic respond(input logic [SD-1:0] exp);
        exp_evt_q.push_back({1'b0, exp});
        last_res = exp;
        repeat ($urandom_range(0, 4)) step();
        step();
        i_rx_done = 1'b1;
        i_rx_data = alu(line_b[0], line_b[1], line_b[2][SO-1:0]);
        wait_idle();
        check("result_after_txn", o_result, exp);
    endtask

    task automatic run_normal(input logic [SD-1:0] a, input logic [SD-1:0] b, input logic [SO-1:0] op);
        start_txn(a, b, op);
        serve_tx(3);
        respond(alu(a, b, op));
    endtask

    // No reply: exactly TT ticks expire the wait; coincide sends the result
    // together with the final tick instead.
    task automatic run_timeout(input logic [SD-1:0] a, input logic [SD-1:0] b,
                               input logic [SO-1:0] op, input bit coincide);
        auto_tick = 1'b0;
        start_txn(a, b, op);
        serve_tx(3);
        for (int k = 1; k < TT; k++) begin
            repeat ($urandom_range(0, 2)) step();
            step();
            i_tick = 1'b1;
        end
        step();
        check("busy_before_final_tick", o_busy, 1);
        check("no_early_timeout", o_timeout, 0);
        i_tick = 1'b1;
        if (coincide) begin
            i_rx_done = 1'b1;
            i_rx_data = alu(line_b[0], line_b[1], line_b[2][SO-1:0]);
            exp_evt_q.push_back({1'b0, alu(a, b, op)});
            last_res = alu(a, b, op);
        end else begin
            exp_evt_q.push_back({1'b1, {SD{1'b0}}});
        end
        step();
        if (coincide) begin
            check("coinc_result_valid", o_result_valid, 1);
            check("coinc_timeout_low", o_timeout, 0);
        end else begin
            check("timeout_pulse", o_timeout, 1);
            check("timeout_no_valid", o_result_valid, 0);
        end
        check("result_after_wait", o_result, last_res);
        check("busy_after_wait", o_busy, 0);
        auto_tick = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_tx_signal"}, o_tx_signal, 0);
        check({tag, "_tx_byte"}, o_tx_data_byte, 0);
        check({tag, "_result"}, o_result, 0);
        check({tag, "_result_valid"}, o_result_valid, 0);
        check({tag, "_timeout"}, o_timeout, 0);
    endtask

    task automatic stimulus();
        int n;
        // Reset state.
        repeat (3) step();
        check_all_zero("reset");
        i_reset = 1'b0;
        last_res = '0;

        // Directed loopback: 2 + 4.
        start_txn(8'h02, 8'h04, 6'h20);
        serve_tx(3);
        respond(8'h06);

        // Silent far end: timeout after TT ticks, result kept.
        run_timeout(8'h10, 8'h20, 6'h24, 1'b0);

        // Start pulsed in WAIT_B with A=0xFF is ignored.
        inj_start = 1'b1;
        run_normal(8'h11, 8'h22, 6'h22);
        inj_start = 1'b0;

        // Stray result byte in IDLE and in WAIT_A.
        step();
        i_rx_done = 1'b1;
        i_rx_data = 8'h55;
        repeat (3) step();
        check("stray_idle_result", o_result, last_res);
        check("stray_idle_busy", o_busy, 0);
        inj_rx = 1'b1;
        run_normal(8'h3C, 8'h0F, 6'h25);
        inj_rx = 1'b0;

        // Reset while in WAIT_OP.
        start_txn(8'hA5, 8'h5A, 6'h26);
        serve_tx(2);
        n = 0;
        while (!o_tx_signal && n < 20) begin
            step();
            n++;
        end
        check("op_strobe_seen", o_tx_signal, 1);
        step();
        i_reset = 1'b1;
        exp_tx_q.delete();
        exp_evt_q.delete();
        last_res = '0;
        step();
        i_reset = 1'b0;
        check_all_zero("abort");
        repeat (5) step();
        run_normal(8'h07, 8'h09, 6'h20);

        // Result coincident with the final tick.
        run_timeout(8'h81, 8'h01, 6'h26, 1'b1);

        // Randomized back-to-back traffic.
        for (int t = 0; t < 25; t++) begin
            inj_start = ($urandom_range(0, 3) == 0);
            inj_rx    = ($urandom_range(0, 3) == 0);
            run_normal(SD'($urandom), SD'($urandom), ops[$urandom_range(0, 6)]);
        end
        inj_start = 1'b0;
        inj_rx    = 1'b0;

        repeat (4) step();
        check("tx_queue_drained", exp_tx_q.size(), 0);
        check("evt_queue_drained", exp_evt_q.size(), 0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_tick    = 1'b0;
        i_start   = 1'b0;
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        i_datoa   = '0;
        i_datob   = '0;
        i_opcode  = '0;
        i_rx_data = '0;
        auto_tick = 1'b1;
        inj_start = 1'b0;
        inj_rx    = 1'b0;
        last_res  = '0;
        ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24; ops[3] = 6'h25;
        ops[4] = 6'h26; ops[5] = 6'h27; ops[6] = 6'h02;
        fork
            monitor();
            stimulus();
            begin
                repeat (50000) @(posedge i_clock);
                checks++;
                errors++;
                $display("FAIL watchdog: got no completion within 50000 cycles expected completion");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 Parameter SIZEDATA, default 8: width of operand, result and UART bytes.
REQ-002 Parameter SIZEOP, default 6: width of opcode; the opcode is zero-extended to SIZEDATA bits on the line.
REQ-003 Parameter TIMEOUT_TICKS, default 4096: number of i_tick pulses allowed for the result byte to arrive.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-005 i_clock  in  1  system clock; all state SHALL change on its rising edge.
REQ-006 i_reset  in  1  synchronous reset, active high.
REQ-007 i_tick  in  1  baud-rate tick from BR_GENERATOR; used only for timeout counting.
REQ-008 i_start  in  1  request pulse; operands are sampled in the same cycle.
REQ-009 i_datoa  in  SIZEDATA  operand A.
REQ-010 i_datob  in  SIZEDATA  operand B.
REQ-011 i_opcode  in  SIZEOP  ALU opcode.
REQ-012 o_tx_signal  out  1  one-cycle send strobe to UART_TX.
REQ-013 o_tx_data_byte  out  SIZEDATA  byte presented to UART_TX.
REQ-014 i_tx_done  in  1  UART_TX byte-complete pulse.
REQ-015 i_rx_done  in  1  UART_RX byte-valid pulse.
REQ-016 i_rx_data  in  SIZEDATA  byte received by UART_RX.
REQ-017 o_busy  out  1  high from the accepted i_start until completion or timeout.
REQ-018 o_result  out  SIZEDATA  last received result; holds its value between transactions.
REQ-019 o_result_valid  out  1  one-cycle pulse when o_result updates.
REQ-020 o_timeout  out  1  one-cycle pulse when the result wait expires.

Function
REQ-021 FSM states: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES.
- IDLE: on i_start, latch A, B and the opcode, then go to SEND_A.
- SEND_x: assert o_tx_signal for exactly one cycle, then go to WAIT_x.
- WAIT_x: advance on i_tx_done (A->SEND_B, B->SEND_OP, OP->WAIT_RES).
REQ-022 Byte order on the line SHALL be operand A, then operand B, then the zero-extended opcode. This matches what INTF expects.
REQ-023 o_tx_data_byte SHALL be driven from the latched registers and held stable from the SEND cycle until the matching i_tx_done.
REQ-024 Between strobes there SHALL be at least one cycle with o_tx_signal low; o_tx_signal is never high outside the SEND states.
REQ-025 In WAIT_RES, i_rx_done SHALL load i_rx_data into o_result, pulse o_result_valid in the next cycle, and return to IDLE.
REQ-026 In WAIT_RES, a tick counter SHALL increment on each i_tick. On reaching TIMEOUT_TICKS:
- pulse o_timeout;
- leave o_result unchanged;
- return to IDLE.
The counter SHALL clear on entering WAIT_RES.
REQ-027 If i_rx_done and the final tick occur in the same cycle, the result SHALL win; o_timeout SHALL stay low.
REQ-028 i_start while o_busy is high SHALL be ignored, and the latched operands SHALL NOT change.
REQ-029 i_rx_done outside WAIT_RES SHALL be ignored. This covers echoes and stray bytes.
REQ-030 i_tx_done outside the WAIT_A, WAIT_B and WAIT_OP states SHALL be ignored.
REQ-031 i_start may be accepted in the cycle after o_result_valid or o_timeout; back-to-back transactions SHALL be supported.
REQ-032 The result SHALL be treated as raw SIZEDATA bits; the block performs no arithmetic or sign interpretation.

Reset
REQ-033 On i_reset, the block SHALL set:
- state to IDLE;
- o_tx_signal, o_result_valid, o_timeout and o_busy to 0;
- o_tx_data_byte, o_result, the operand latches and the tick counter to 0.
REQ-034 Reset asserted mid-transaction SHALL abort it within one cycle, with no further strobe and no result or timeout pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the default values of SIZEDATA, SIZEOP and TIMEOUT_TICKS.
REQ-036 The tick timeout counter SHALL be a sub-module named tick_timer with ports: clear, enable, tick, expired.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- A=0x02, B=0x04, op=0x20 with loopback through INTF/ALU -> TX strobes carry 0x02, 0x04, 0x20 in order; o_result=0x06 with one o_result_valid pulse; o_busy then falls.
- No result byte -> o_timeout pulses after exactly TIMEOUT_TICKS ticks (test value 16); o_result keeps its prior value.
- i_start pulsed in WAIT_B with A=0xFF -> ignored; the transaction completes with the original operands.
- Stray i_rx_done=0x55 in IDLE and in WAIT_A -> o_result and o_result_valid unchanged.
- i_reset in WAIT_OP -> the next cycle shows IDLE with all outputs 0; a following i_start runs a clean transaction.
- i_rx_done coincident with the final tick -> o_result_valid=1 and o_timeout=0.
